// File: rtl/mcpnr_serv_rf_pkg.sv
// Shared constants and types for the bit-serial SERV register file.
package mcpnr_serv_rf_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned RF_AW = 6;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {
    RF_IDLE,
    RF_WAIT,
    RF_STREAM
  } rf_state_e;

  function automatic logic rf_in_range(logic [RF_AW-1:0] idx, int unsigned nreg);
    return 32'(idx) < nreg;
  endfunction

  // Entry 0 is hard-wired zero, so it is never a legal write target.
  function automatic logic rf_wr_ok(logic [RF_AW-1:0] idx, int unsigned nreg);
    return (idx != '0) && rf_in_range(idx, nreg);
  endfunction

endpackage

// File: rtl/mcpnr_serv_rf_if.sv
// SERV register-file request/serial-data bundle; master is serv_top, slave is the RF.
interface mcpnr_serv_rf_if;
  import mcpnr_serv_rf_pkg::*;

  logic             i_rreq;
  logic             i_wreq;
  logic             o_ready;
  logic [RF_AW-1:0] i_rreg0;
  logic [RF_AW-1:0] i_rreg1;
  logic             o_rdata0;
  logic             o_rdata1;
  logic [RF_AW-1:0] i_wreg0;
  logic [RF_AW-1:0] i_wreg1;
  logic             i_wen0;
  logic             i_wen1;
  logic             i_wdata0;
  logic             i_wdata1;

  modport master (
    output i_rreq, i_wreq, i_rreg0, i_rreg1, i_wreg0, i_wreg1,
           i_wen0, i_wen1, i_wdata0, i_wdata1,
    input  o_ready, o_rdata0, o_rdata1
  );

  modport slave (
    input  i_rreq, i_wreq, i_rreg0, i_rreg1, i_wreg0, i_wreg1,
           i_wen0, i_wen1, i_wdata0, i_wdata1,
    output o_ready, o_rdata0, o_rdata1
  );

endinterface

// File: rtl/mcpnr_rf_bitcnt.sv
// 5-bit serial bit-position counter with enable, synchronous clear and last flag.
module mcpnr_rf_bitcnt
  import mcpnr_serv_rf_pkg::*;
(
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_last
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt  = cnt_q;
  assign o_last = (cnt_q == '1);

endmodule

// File: rtl/mcpnr_serv_rf.sv
// Flop-based bit-serial register file for SERV: two serial read and two serial write ports.
// Define MCPNR_RF_DEBUG_PORT_EN to add a combinational parallel debug view (i_dbg_sel/o_dbg_data).
module mcpnr_serv_rf
  import mcpnr_serv_rf_pkg::*;
#(
  parameter int unsigned NREG     = 36,
  parameter int unsigned READ_LAT = 1
) (
  input  logic             clk,
  input  logic             i_rst_n,
  mcpnr_serv_rf_if.slave   rf
`ifdef MCPNR_RF_DEBUG_PORT_EN
  ,
  input  logic [RF_AW-1:0] i_dbg_sel,
  output logic [XLEN-1:0]  o_dbg_data
`endif
);

  localparam int unsigned LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  logic [XLEN-1:0]  mem_q [NREG];
  logic [XLEN-1:0]  mem_d [NREG];

  rf_state_e        state_q, state_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [RF_AW-1:0] rreg0_q, rreg0_d;
  logic [RF_AW-1:0] rreg1_q, rreg1_d;
  logic             ready_q, ready_d;
  logic             wack_q, wack_d;
  logic             rdata0_q, rdata0_d;
  logic             rdata1_q, rdata1_d;

  logic             rd_ready;
  logic             rcnt_en, rcnt_clr;
  logic [CNT_W-1:0] rcnt, rnext, wcnt0, wcnt1;
  logic             rlast, wlast0, wlast1;
  logic [XLEN-1:0]  rword0, rword1;

  mcpnr_rf_bitcnt u_rcnt (
    .clk(clk), .i_rst_n(i_rst_n), .i_en(rcnt_en), .i_clr(rcnt_clr),
    .o_cnt(rcnt), .o_last(rlast)
  );

  mcpnr_rf_bitcnt u_wcnt0 (
    .clk(clk), .i_rst_n(i_rst_n), .i_en(rf.i_wen0), .i_clr(1'b0),
    .o_cnt(wcnt0), .o_last(wlast0)
  );

  mcpnr_rf_bitcnt u_wcnt1 (
    .clk(clk), .i_rst_n(i_rst_n), .i_en(rf.i_wen1), .i_clr(1'b0),
    .o_cnt(wcnt1), .o_last(wlast1)
  );

  assign rword0 = rf_in_range(rreg0_q, NREG) ? mem_q[rreg0_q] : '0;
  assign rword1 = rf_in_range(rreg1_q, NREG) ? mem_q[rreg1_q] : '0;
  assign rnext  = rcnt + 1'b1;

  // rcnt tracks the bit currently on o_rdata; the next bit is fetched a cycle
  // ahead so the output stays registered and sees pre-edge contents.
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    rreg0_d  = rreg0_q;
    rreg1_d  = rreg1_q;
    rdata0_d = 1'b0;
    rdata1_d = 1'b0;
    rd_ready = 1'b0;
    rcnt_en  = 1'b0;
    rcnt_clr = 1'b0;
    unique case (state_q)
      RF_IDLE: begin
        if (rf.i_rreq) begin
          rreg0_d  = rf.i_rreg0;
          rreg1_d  = rf.i_rreg1;
          lat_d    = LAT_W'(READ_LAT - 1);
          rcnt_clr = 1'b1;
          rd_ready = (READ_LAT == 1);
          state_d  = RF_WAIT;
        end
      end
      RF_WAIT: begin
        if (lat_q == '0) begin
          rdata0_d = rword0[0];
          rdata1_d = rword1[0];
          state_d  = RF_STREAM;
        end else begin
          lat_d    = lat_q - 1'b1;
          rd_ready = (lat_q == LAT_W'(1));
        end
      end
      RF_STREAM: begin
        rcnt_en = 1'b1;
        if (rlast) begin
          state_d = RF_IDLE;
        end else begin
          rdata0_d = rword0[rnext];
          rdata1_d = rword1[rnext];
        end
      end
      default: state_d = RF_IDLE;
    endcase
    wack_d  = rf.i_wreq && !wack_q;
    ready_d = rd_ready || wack_d;
  end

  // Port 1 is applied last so it wins a same-entry, same-bit collision.
  always_comb begin
    mem_d = mem_q;
    if (rf.i_wen0 && rf_wr_ok(rf.i_wreg0, NREG)) begin
      mem_d[rf.i_wreg0][wcnt0] = rf.i_wdata0;
    end
    if (rf.i_wen1 && rf_wr_ok(rf.i_wreg1, NREG)) begin
      mem_d[rf.i_wreg1][wcnt1] = rf.i_wdata1;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= RF_IDLE;
      lat_q    <= '0;
      rreg0_q  <= '0;
      rreg1_q  <= '0;
      ready_q  <= 1'b0;
      wack_q   <= 1'b0;
      rdata0_q <= 1'b0;
      rdata1_q <= 1'b0;
      for (int unsigned i = 0; i < NREG; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      lat_q    <= lat_d;
      rreg0_q  <= rreg0_d;
      rreg1_q  <= rreg1_d;
      ready_q  <= ready_d;
      wack_q   <= wack_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      mem_q    <= mem_d;
    end
  end

  assign rf.o_ready  = ready_q;
  assign rf.o_rdata0 = rdata0_q;
  assign rf.o_rdata1 = rdata1_q;

`ifdef MCPNR_RF_DEBUG_PORT_EN
  assign o_dbg_data = rf_in_range(i_dbg_sel, NREG) ? mem_q[i_dbg_sel] : '0;
`endif

  rreq_while_busy: assert property (@(posedge clk) disable iff (!i_rst_n)
    rf.i_rreq |-> (state_q == RF_IDLE));

  wreg0_stable: assert property (@(posedge clk) disable iff (!i_rst_n)
    (rf.i_wen0 && !wlast0) |=> (!rf.i_wen0 || $stable(rf.i_wreg0)));

  wreg1_stable: assert property (@(posedge clk) disable iff (!i_rst_n)
    (rf.i_wen1 && !wlast1) |=> (!rf.i_wen1 || $stable(rf.i_wreg1)));

endmodule

// File: tb/tb_mcpnr_serv_rf.sv
// Scoreboard bench for mcpnr_serv_rf: word-level register model, queued expectations, serial monitor.
module tb_mcpnr_serv_rf;

  localparam int unsigned NREG     = 36;
  localparam int unsigned READ_LAT = 1;

  typedef struct {
    int          rdy_cyc;
    logic [31:0] w0;
    logic [31:0] w1;
  } rd_exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  logic [31:0] model [64];
  int          rdy_q [$];
  rd_exp_t     rd_q [$];

  mcpnr_serv_rf_if rf_if ();

`ifdef MCPNR_RF_DEBUG_PORT_EN
  logic [5:0]  dbg_sel;
  logic [31:0] dbg_data;
`endif

  mcpnr_serv_rf #(.NREG(NREG), .READ_LAT(READ_LAT)) dut (
    .clk(clk),
    .i_rst_n(rst_n),
    .rf(rf_if)
`ifdef MCPNR_RF_DEBUG_PORT_EN
    ,
    .i_dbg_sel(dbg_sel),
    .o_dbg_data(dbg_data)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [31:0] model_rd(int unsigned idx);
    return (idx < NREG) ? model[idx] : 32'h0;
  endfunction

  function automatic void model_wr(int unsigned idx, logic [31:0] val);
    if (idx != 0 && idx < NREG) model[idx] = val;
  endfunction

  function automatic void push_ready(int c);
    if (rdy_q.size() == 0 || rdy_q[$] != c) rdy_q.push_back(c);
  endfunction

  function automatic int unsigned pick_idx();
    return ($urandom_range(0, 3) == 0) ? $urandom_range(32, 47) : $urandom_range(0, 12);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic stream_bits(input bit e0, input logic [31:0] v0,
                             input bit e1, input logic [31:0] v1);
    for (int i = 0; i < 32; i++) begin
      rf_if.i_wen0   = e0;
      rf_if.i_wen1   = e1;
      rf_if.i_wdata0 = v0[i];
      rf_if.i_wdata1 = v1[i];
      tick();
    end
    rf_if.i_wen0   = 1'b0;
    rf_if.i_wen1   = 1'b0;
    rf_if.i_wdata0 = 1'b0;
    rf_if.i_wdata1 = 1'b0;
  endtask

  task automatic write_pair(input bit e0, input int unsigned r0, input logic [31:0] v0,
                            input bit e1, input int unsigned r1, input logic [31:0] v1);
    rf_if.i_wreq  = 1'b1;
    rf_if.i_wreg0 = 6'(r0);
    rf_if.i_wreg1 = 6'(r1);
    push_ready(cyc + 1);
    tick();
    rf_if.i_wreq = 1'b0;
    stream_bits(e0, v0, e1, v1);
    if (e0) model_wr(r0, v0);
    if (e1) model_wr(r1, v1);
  endtask

  task automatic read_issue(input int unsigned r0, input int unsigned r1);
    rd_exp_t e;
    rf_if.i_rreq  = 1'b1;
    rf_if.i_rreg0 = 6'(r0);
    rf_if.i_rreg1 = 6'(r1);
    push_ready(cyc + READ_LAT);
    e.rdy_cyc = cyc + READ_LAT;
    e.w0 = model_rd(r0);
    e.w1 = model_rd(r1);
    rd_q.push_back(e);
    tick();
    rf_if.i_rreq = 1'b0;
  endtask

  task automatic read(input int unsigned r0, input int unsigned r1);
    read_issue(r0, r1);
    repeat (READ_LAT + 34) tick();
  endtask

  // Read and write requested together; the read must return the pre-write word.
  task automatic rw_concurrent(input int unsigned r, input int unsigned w, input logic [31:0] v);
    rd_exp_t e;
    rf_if.i_wreq  = 1'b1;
    rf_if.i_wreg0 = 6'(w);
    push_ready(cyc + 1);
    rf_if.i_rreq  = 1'b1;
    rf_if.i_rreg0 = 6'(r);
    rf_if.i_rreg1 = 6'(r);
    push_ready(cyc + READ_LAT);
    e.rdy_cyc = cyc + READ_LAT;
    e.w0 = model_rd(r);
    e.w1 = model_rd(r);
    rd_q.push_back(e);
    tick();
    rf_if.i_wreq = 1'b0;
    rf_if.i_rreq = 1'b0;
    stream_bits(1'b1, v, 1'b0, 32'h0);
    model_wr(w, v);
    repeat (READ_LAT + 3) tick();
  endtask

  // Monitor: checks every ready pulse against expectations and reassembles read streams.
  bit          collecting = 1'b0;
  int unsigned bi = 0;
  logic [31:0] acc0, acc1;

  always @(negedge clk) begin
    bit exp_rdy;
    if (!rst_n) begin
      collecting = 1'b0;
      bi = 0;
    end else begin
      exp_rdy = (rdy_q.size() > 0) && (rdy_q[0] == cyc);
      if (exp_rdy) void'(rdy_q.pop_front());
      if (exp_rdy || rf_if.o_ready) check("ready", 32'(rf_if.o_ready), 32'(exp_rdy));
      if (collecting) begin
        acc0[bi] = rf_if.o_rdata0;
        acc1[bi] = rf_if.o_rdata1;
        bi++;
        if (bi == 32) begin
          rd_exp_t e;
          e = rd_q.pop_front();
          check("rdata0_word", acc0, e.w0);
          check("rdata1_word", acc1, e.w1);
          collecting = 1'b0;
        end
      end else if (rd_q.size() > 0 && rd_q[0].rdy_cyc == cyc) begin
        collecting = 1'b1;
        bi = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w;
    rst_n          = 1'b0;
    rf_if.i_rreq   = 1'b0;
    rf_if.i_wreq   = 1'b0;
    rf_if.i_rreg0  = '0;
    rf_if.i_rreg1  = '0;
    rf_if.i_wreg0  = '0;
    rf_if.i_wreg1  = '0;
    rf_if.i_wen0   = 1'b0;
    rf_if.i_wen1   = 1'b0;
    rf_if.i_wdata0 = 1'b0;
    rf_if.i_wdata1 = 1'b0;
`ifdef MCPNR_RF_DEBUG_PORT_EN
    dbg_sel = '0;
`endif
    foreach (model[i]) model[i] = 32'h0;

    repeat (3) tick();
    check("rst_ready", 32'(rf_if.o_ready), 32'h0);
    check("rst_rdata0", 32'(rf_if.o_rdata0), 32'h0);
    check("rst_rdata1", 32'(rf_if.o_rdata1), 32'h0);
    rst_n = 1'b1;
    tick();

    write_pair(1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 32'h0);
    read(5, 0);

    write_pair(1'b1, 0, 32'hFFFFFFFF, 1'b0, 0, 32'h0);
    read(0, 0);

    write_pair(1'b1, 7, 32'h0000FFFF, 1'b0, 0, 32'h0);
    rw_concurrent(7, 7, 32'hFFFF0000);
    read(7, 7);

    write_pair(1'b1, 9, 32'hA5A5A5A5, 1'b1, 9, 32'h3C3C3C3C);
    write_pair(1'b1, 10, 32'h01234567, 1'b1, 11, 32'h89ABCDEF);
    read(10, 11);
    read(9, 5);

    write_pair(1'b1, 35, 32'h80000001, 1'b1, 36, 32'h12345678);
    write_pair(1'b1, 63, 32'hCAFEF00D, 1'b0, 0, 32'h0);
    read(35, 36);
    read(63, 0);

    for (int n = 0; n < 30; n++) begin
      int unsigned a, b;
      logic [31:0] va, vb;
      a  = pick_idx();
      b  = pick_idx();
      va = $urandom;
      vb = $urandom;
      case ($urandom_range(0, 2))
        0:       write_pair(1'b1, a, va, 1'b0, b, vb);
        1:       write_pair(1'b1, a, va, 1'b1, b, vb);
        default: read(a, b);
      endcase
    end

`ifdef MCPNR_RF_DEBUG_PORT_EN
    write_pair(1'b1, 3, 32'h12345678, 1'b0, 0, 32'h0);
    dbg_sel = 6'd3;
    #1;
    check("dbg_x3", dbg_data, 32'h12345678);
    dbg_sel = 6'd40;
    #1;
    check("dbg_x40", dbg_data, 32'h0);
`endif

    // Reset while bit 10 of a read stream is on the output.
    write_pair(1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 32'h0);
    write_pair(1'b1, 7, 32'h0000FFFF, 1'b0, 0, 32'h0);
    read_issue(5, 7);
    repeat (11) tick();
    w = model_rd(5);
    check("pre_rst_bit10", 32'(rf_if.o_rdata0), 32'(w[10]));
    rst_n = 1'b0;
    rd_q.delete();
    rdy_q.delete();
    foreach (model[i]) model[i] = 32'h0;
    #1;
    check("async_rst_rdata0", 32'(rf_if.o_rdata0), 32'h0);
    check("async_rst_ready", 32'(rf_if.o_ready), 32'h0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    read(5, 7);
    read(35, 9);

    repeat (4) tick();
    check("drain_read_q", 32'(rd_q.size()), 32'h0);
    check("drain_ready_q", 32'(rdy_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
